welcome_fb_ctrl: RTL and testbench
==================================

# welcome_fb_ctrl

Sequencer and arbiter for the 640x480, 1-bit welcome-screen framebuffer RAM, which has one write port and one registered read port. It owns the RAM's write port and shares it between an internal full-screen clear engine and an external pixel-writer stream using a valid/ready handshake. It also drives the read port from the VGA controller's DrawX/DrawY and returns a masked, pipelined pixel bit to the colour mapper.

## Interface
Parameters:
- H_RES, 640, visible columns
- V_RES, 480, visible rows
- ADDR_W, 19, framebuffer address width (H_RES*V_RES = 307200 entries)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current VGA column
- DrawY  in  10  current VGA row
- clear_req  in  1  request full-screen fill; sampled only in IDLE
- clear_val  in  1  fill value; latched when the clear is accepted
- clear_busy  out  1  high while the clear sweep is writing
- clear_done  out  1  one-cycle pulse after the last clear write
- pix_valid  in  1  writer has a pixel
- pix_ready  out  1  controller accepts a pixel this cycle
- pix_x  in  10  pixel column
- pix_y  in  10  pixel row
- pix_data  in  1  pixel value
- ram_we  out  1  RAM write enable
- ram_write_address  out  19  RAM write address
- ram_data_In  out  1  RAM write data
- ram_read_address  out  19  RAM read address
- ram_data_Out  in  1  RAM read data; valid one cycle after ram_read_address
- pixel_on  out  1  framebuffer bit for the (DrawX, DrawY) presented two cycles earlier
- drop_count  out  8  saturating count of accepted out-of-range pixels

## Operation
- The FSM has two states, IDLE and CLEAR. The write port is driven by registered outputs.
- In IDLE:
  - clear_req=1 moves to CLEAR, latches clear_val and zeroes the sweep counter.
  - pix_ready = (state==IDLE) && !clear_req && !Reset. This is combinational, and clear takes priority over a pixel in the same cycle.
- Pixel accept means pix_valid && pix_ready in cycle t. In cycle t+1:
  - If in range (pix_x < 640, pix_y < 480): ram_we=1, ram_write_address = pix_y*640 + pix_x, ram_data_In = pix_data.
  - If out of range: ram_we=0 and drop_count increments, saturating at 255.
  - Back-to-back accepts sustain one write per cycle.
- In CLEAR:
  - Each cycle writes clear_val at the sweep counter, then increments the counter.
  - After address 307199 the FSM returns to IDLE.
  - clear_req is ignored during CLEAR (no restart).
  - pix_ready=0 throughout.
- Address arithmetic: y*640 is computed as (y<<9)+(y<<7) plus x, 19-bit, with no wrap for in-range inputs.
- Read path:
  - ram_read_address is registered from DrawX/DrawY.
  - Out-of-range DrawX/DrawY forces the address to 0 and sets a blank flag. That flag is pipelined alongside the read.
  - pixel_on = ram_data_Out && !blank_d.
- Reset mid-clear aborts the sweep. RAM contents are then undefined beyond the last written address, and no clear_done pulse is issued.

## Timing
- Reset values: state=IDLE, ram_we=0, ram_write_address=0, ram_data_In=0, ram_read_address=0, clear_busy=0, clear_done=0, pixel_on=0, drop_count=0. pix_ready=0 while Reset is high.
- Clear request at cycle t:
  - Writes to addresses 0..307199 occur on cycles t+1..t+307200.
  - clear_busy is high on exactly those cycles.
  - clear_done is high at t+307201.
  - pix_ready returns to 1 at t+307201.
- Pixel write latency: 1 cycle from handshake to ram_we.
- Read latency: 2 cycles from DrawX/DrawY to pixel_on (1 register, 1 RAM).
- Read and write paths are independent. A same-address read and write in one cycle returns the old RAM data.

## Structure
- Package fb_pkg holds:
  - the constants H_RES, V_RES, FB_DEPTH=307200 and ADDR_W=19
  - typedef fb_addr_t (logic [18:0])
  - enum fb_state_t {IDLE, CLEAR}
- Sub-module fb_addr_calc: combinational (x, y) -> (addr, in_range). It is instantiated twice, once for the pixel writer and once for the read path.

## Test plan
- Reset, then idle: all outputs at reset values; pix_ready=1 on the first cycle after Reset deasserts.
- Pixel write x=639, y=479, data=1 accepted at t -> at t+1, ram_we=1, ram_write_address=307199, ram_data_In=1. Reading DrawX=639, DrawY=479 later gives pixel_on=1 two cycles after presentation.
- Out-of-range pixels:
  - x=640, y=0 accepted -> no write, drop_count=1.
  - 300 such pixels -> drop_count=255.
- clear_req with clear_val=1 at t, with pix_valid=1 in the same cycle:
  - pixel not accepted; pix_ready=0.
  - writes at addresses 0..307199; clear_done at t+307201.
  - a clear_req pulse mid-sweep does not restart the sweep.
- Reset asserted at sweep address 1000 -> the next cycle is IDLE, ram_we=0, clear_busy=0, no clear_done pulse.
- Read masking: DrawX=700, DrawY=10 with RAM word 0 = 1 -> ram_read_address=0 and pixel_on=0 two cycles later.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, types and address helper for the welcome-screen framebuffer.
// The 640-wide row stride is folded into shifts so no multiplier is inferred.
package fb_pkg;
    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = 19;

    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    // y*640 + x as (y<<9) + (y<<7) + x; never wraps for in-range coordinates
    function automatic fb_addr_t xy_to_addr(input logic [9:0] x, input logic [9:0] y);
        fb_addr_t y_ext;
        y_ext = fb_addr_t'(y);
        return (y_ext << 9) + (y_ext << 7) + fb_addr_t'(x);
    endfunction
endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (x, y) -> linear framebuffer address plus in-range flag.
// Zero latency; no flow control.
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int H_MAX = 640,
    parameter int V_MAX = 480
) (
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output fb_addr_t   o_addr,
    output logic       o_in_range
);
    localparam logic [9:0] H_LIM = 10'(H_MAX);
    localparam logic [9:0] V_LIM = 10'(V_MAX);

    assign o_addr     = xy_to_addr(i_x, i_y);
    assign o_in_range = (i_x < H_LIM) && (i_y < V_LIM);
endmodule

// File: rtl/welcome_fb_ctrl.sv
// Owns the framebuffer write port (clear sweep vs. pixel stream) and the read port; writes land 1 cycle after accept, pixel_on 2 cycles after DrawX/DrawY.
// pix_ready drops for the whole clear sweep and in any cycle a clear is requested.
module welcome_fb_ctrl #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              clear_req,
    input  logic              clear_val,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pix_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic              ram_data_In,
    output logic [ADDR_W-1:0] ram_read_address,
    input  logic              ram_data_Out,
    output logic              pixel_on,
    output logic [7:0]        drop_count
);
    import fb_pkg::*;

    localparam fb_addr_t SWEEP_LAST = fb_addr_t'(H_RES * V_RES - 1);

    fb_state_t  r_state;
    logic       r_clear_val;
    fb_addr_t   r_sweep;
    logic       r_we;
    fb_addr_t   r_waddr;
    logic       r_wdat;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_drop;
    fb_addr_t   r_raddr;
    logic       r_blank;
    logic       r_blank_d;

    fb_addr_t   w_pix_addr;
    logic       w_pix_in_range;
    fb_addr_t   w_rd_addr;
    logic       w_rd_in_range;
    logic       w_pix_ready;
    logic       w_accept;

    fb_addr_calc #(
        .H_MAX (H_RES),
        .V_MAX (V_RES)
    ) u_pix_calc (
        .i_x        (pix_x),
        .i_y        (pix_y),
        .o_addr     (w_pix_addr),
        .o_in_range (w_pix_in_range)
    );

    fb_addr_calc #(
        .H_MAX (H_RES),
        .V_MAX (V_RES)
    ) u_rd_calc (
        .i_x        (DrawX),
        .i_y        (DrawY),
        .o_addr     (w_rd_addr),
        .o_in_range (w_rd_in_range)
    );

    // A same-cycle clear request wins over a pending pixel
    assign w_pix_ready = (r_state == IDLE) && !clear_req && !Reset;
    assign w_accept    = pix_valid && w_pix_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_clear_val <= 1'b0;
            r_sweep     <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdat      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state     <= CLEAR;
                        r_clear_val <= clear_val;
                        r_sweep     <= '0;
                        r_we        <= 1'b1;
                        r_waddr     <= '0;
                        r_wdat      <= clear_val;
                        r_busy      <= 1'b1;
                    end else if (w_accept) begin
                        if (w_pix_in_range) begin
                            r_we    <= 1'b1;
                            r_waddr <= w_pix_addr;
                            r_wdat  <= pix_data;
                        end else if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end
                end
                CLEAR: begin
                    // r_sweep is the address currently on the write port
                    if (r_sweep == SWEEP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_sweep <= r_sweep + fb_addr_t'(1);
                        r_waddr <= r_sweep + fb_addr_t'(1);
                        r_wdat  <= r_clear_val;
                        r_we    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Blank flags reset high so pixel_on reads 0 regardless of RAM output
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_raddr   <= '0;
            r_blank   <= 1'b1;
            r_blank_d <= 1'b1;
        end else begin
            r_raddr   <= w_rd_in_range ? w_rd_addr : '0;
            r_blank   <= !w_rd_in_range;
            r_blank_d <= r_blank;
        end
    end

    assign pix_ready         = w_pix_ready;
    assign clear_busy        = r_busy;
    assign clear_done        = r_done;
    assign ram_we            = r_we;
    assign ram_write_address = r_waddr;
    assign ram_data_In       = r_wdat;
    assign ram_read_address  = r_raddr;
    assign drop_count        = r_drop;
    assign pixel_on          = ram_data_Out && !r_blank_d;
endmodule

// File: tb/tb_welcome_fb_ctrl.sv
// Bench for welcome_fb_ctrl with a behavioural RAM and a reference image of the screen.
// Uses a short screen (VR rows) so a full clear sweep stays a few tens of thousands of cycles.
module tb_welcome_fb_ctrl;
    localparam int HR    = 640;
    localparam int VR    = 48;
    localparam int DEPTH = HR * VR;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        clear_req, clear_val, clear_busy, clear_done;
    logic        pix_valid, pix_ready, pix_data;
    logic [9:0]  pix_x, pix_y;
    logic        ram_we, ram_data_In, ram_data_Out, pixel_on;
    logic [18:0] ram_write_address, ram_read_address;
    logic [7:0]  drop_count;

    bit mem     [0:DEPTH-1];
    bit ref_img [0:DEPTH-1];
    int wx[$];
    int wy[$];
    int n_vec = 0;
    int n_err = 0;
    int drops_model = 0;

    welcome_fb_ctrl #(.H_RES(HR), .V_RES(VR), .ADDR_W(19)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .DrawX             (DrawX),
        .DrawY             (DrawY),
        .clear_req         (clear_req),
        .clear_val         (clear_val),
        .clear_busy        (clear_busy),
        .clear_done        (clear_done),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_data          (pix_data),
        .ram_we            (ram_we),
        .ram_write_address (ram_write_address),
        .ram_data_In       (ram_data_In),
        .ram_read_address  (ram_read_address),
        .ram_data_Out      (ram_data_Out),
        .pixel_on          (pixel_on),
        .drop_count        (drop_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single write port, registered read port returning old data on collision
    always @(posedge Clk) begin
        if (ram_we && int'(ram_write_address) < DEPTH)
            mem[ram_write_address] <= ram_data_In;
        ram_data_Out <= (int'(ram_read_address) < DEPTH) ? mem[ram_read_address] : 1'b0;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; clear_req = 1'b0; clear_val = 1'b0;
        pix_valid = 1'b1; pix_x = 10'd5; pix_y = 10'd5; pix_data = 1'b1;
        DrawX = 10'd700; DrawY = 10'd3;
        step(); step();
        n_vec++;
        if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
        n_vec++;
        if ({ram_we, ram_write_address, ram_data_In} !== 21'd0) begin
            n_err++; $display("FAIL reset_write_port: we=%b addr=%0d dat=%b want 0/0/0", ram_we, ram_write_address, ram_data_In);
        end
        n_vec++;
        if ({ram_read_address, clear_busy, clear_done, pixel_on, drop_count} !== 30'd0) begin
            n_err++; $display("FAIL reset_outputs: raddr=%0d busy=%b done=%b pix_on=%b drops=%0d want all 0",
                              ram_read_address, clear_busy, clear_done, pixel_on, drop_count);
        end
        Reset = 1'b0; pix_valid = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
        #1;
        n_vec++;
        if (pix_ready !== 1'b1) begin n_err++; $display("FAIL first_idle_pix_ready: got %b want 1", pix_ready); end
        drops_model = 0;
    endtask

    task automatic test_pixel_corner();
        step();
        pix_valid = 1'b1; pix_x = 10'(HR - 1); pix_y = 10'(VR - 1); pix_data = 1'b1;
        #1;
        n_vec++;
        if (pix_ready !== 1'b1) begin n_err++; $display("FAIL corner_ready: got %b want 1", pix_ready); end
        step();
        pix_valid = 1'b0;
        n_vec++;
        if (ram_we !== 1'b1 || int'(ram_write_address) != DEPTH - 1 || ram_data_In !== 1'b1) begin
            n_err++; $display("FAIL corner_write: we=%b addr=%0d dat=%b want 1/%0d/1", ram_we, ram_write_address, ram_data_In, DEPTH - 1);
        end
        ref_img[DEPTH-1] = 1'b1;
        step();
        n_vec++;
        if (ram_we !== 1'b0) begin n_err++; $display("FAIL corner_single_write: we=%b want 0", ram_we); end
        DrawX = 10'(HR - 1); DrawY = 10'(VR - 1);
        step();
        n_vec++;
        if (int'(ram_read_address) != DEPTH - 1) begin
            n_err++; $display("FAIL corner_raddr: got %0d want %0d", ram_read_address, DEPTH - 1);
        end
        step();
        n_vec++;
        if (pixel_on !== 1'b1) begin n_err++; $display("FAIL corner_readback: pixel_on=%b want 1", pixel_on); end
    endtask

    task automatic test_drop_single();
        step();
        pix_valid = 1'b1; pix_x = 10'd640; pix_y = 10'd0; pix_data = 1'b1;
        step();
        pix_valid = 1'b0;
        drops_model = 1;
        n_vec++;
        if (ram_we !== 1'b0 || drop_count !== 8'd1) begin
            n_err++; $display("FAIL drop_single: we=%b drops=%0d want 0/1", ram_we, drop_count);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_we, exp_dat, v;
        int   exp_addr, x, y;
        exp_we = 1'b0; exp_dat = 1'b0; exp_addr = 0;
        for (int i = 0; i <= 300; i++) begin
            step();
            n_vec++;
            if (ram_we !== exp_we || (exp_we && (int'(ram_write_address) != exp_addr || ram_data_In !== exp_dat))) begin
                n_err++; $display("FAIL b2b_write cyc %0d: we=%b addr=%0d dat=%b want we=%b addr=%0d dat=%b",
                                  i, ram_we, ram_write_address, ram_data_In, exp_we, exp_addr, exp_dat);
            end
            n_vec++;
            if (drop_count !== 8'(drops_model)) begin
                n_err++; $display("FAIL b2b_drops cyc %0d: got %0d want %0d", i, drop_count, drops_model);
            end
            if (i == 300) begin
                pix_valid = 1'b0;
            end else begin
                v = ($urandom_range(3) != 0);
                x = $urandom_range(700);
                y = $urandom_range(VR + 8);
                pix_valid = v; pix_x = 10'(x); pix_y = 10'(y); pix_data = 1'($urandom_range(1));
                #1;
                n_vec++;
                if (pix_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready cyc %0d: got %b want 1", i, pix_ready); end
                exp_we = 1'b0;
                if (v) begin
                    if (x < HR && y < VR) begin
                        exp_we = 1'b1; exp_addr = y * HR + x; exp_dat = pix_data;
                        ref_img[exp_addr] = pix_data;
                        wx.push_back(x); wy.push_back(y);
                    end else if (drops_model < 255) begin
                        drops_model++;
                    end
                end
            end
        end
    endtask

    task automatic test_read_stream();
        logic q[$];
        logic e;
        int   x, y, k;
        for (int i = 0; i < 62; i++) begin
            step();
            if (i >= 2) begin
                e = q.pop_front();
                n_vec++;
                if (pixel_on !== e) begin n_err++; $display("FAIL read_stream %0d: pixel_on=%b want %b", i, pixel_on, e); end
            end
            if (i < 60) begin
                if ($urandom_range(1) == 1 && wx.size() > 0) begin
                    k = $urandom_range(wx.size() - 1);
                    x = wx[k]; y = wy[k];
                end else begin
                    x = $urandom_range(700); y = $urandom_range(VR + 5);
                end
                DrawX = 10'(x); DrawY = 10'(y);
                q.push_back((x < HR && y < VR) ? ref_img[y * HR + x] : 1'b0);
            end
        end
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 300; i++) begin
            step();
            pix_valid = 1'b1;
            pix_x = ($urandom_range(1) == 1) ? 10'(HR + $urandom_range(300)) : 10'($urandom_range(HR - 1));
            pix_y = (pix_x >= 10'(HR)) ? 10'($urandom_range(VR - 1)) : 10'(VR + $urandom_range(200));
        end
        step();
        pix_valid = 1'b0;
        n_vec++;
        if (drop_count !== 8'd255 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL drop_saturate: drops=%0d we=%b want 255/0", drop_count, ram_we);
        end
        drops_model = 255;
    endtask

    task automatic test_clear();
        int bad, first_bad;
        logic [22:0] seen;
        bad = 0; first_bad = -1; seen = '0;
        step();
        clear_req = 1'b1; clear_val = 1'b1;
        pix_valid = 1'b1; pix_x = 10'd3; pix_y = 10'd2; pix_data = 1'b0;
        #1;
        n_vec++;
        if (pix_ready !== 1'b0) begin n_err++; $display("FAIL clear_vs_pixel_ready: got %b want 0", pix_ready); end
        for (int k = 0; k < DEPTH; k++) begin
            step();
            if (ram_we !== 1'b1 || int'(ram_write_address) != k || ram_data_In !== 1'b1
                || clear_busy !== 1'b1 || clear_done !== 1'b0) begin
                if (bad == 0) begin
                    first_bad = k;
                    seen = {ram_we, ram_write_address, ram_data_In, clear_busy, clear_done};
                end
                bad++;
            end
            clear_val = 1'b0;
            clear_req = (k == 100);
            #1;
            if (k == 50 || k == 100) begin
                n_vec++;
                if (pix_ready !== 1'b0) begin n_err++; $display("FAIL clear_busy_ready at %0d: got %b want 0", k, pix_ready); end
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL clear_sweep: %0d bad cycles, first at %0d saw we/addr/dat/busy/done=%h want addr=%0d", bad, first_bad, seen, first_bad);
        end
        step();
        n_vec++;
        if (clear_done !== 1'b1 || clear_busy !== 1'b0 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL clear_done: done=%b busy=%b we=%b want 1/0/0", clear_done, clear_busy, ram_we);
        end
        pix_valid = 1'b0;
        #1;
        n_vec++;
        if (pix_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready_back: got %b want 1", pix_ready); end
        step();
        n_vec++;
        if (clear_done !== 1'b0) begin n_err++; $display("FAIL clear_done_width: done=%b want 0", clear_done); end
        for (int i = 0; i < DEPTH; i++) ref_img[i] = 1'b1;
    endtask

    task automatic test_reset_mid_clear();
        int bad;
        bad = 0;
        step();
        clear_req = 1'b1; clear_val = 1'b0;
        for (int k = 0; k <= 1000; k++) begin
            step();
            clear_req = 1'b0;
            if (ram_we !== 1'b1 || int'(ram_write_address) != k || ram_data_In !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL abort_sweep_prefix: %0d bad cycles want 0", bad); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_vec++;
        if (ram_we !== 1'b0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            n_err++; $display("FAIL abort_state: we=%b busy=%b done=%b want 0/0/0", ram_we, clear_busy, clear_done);
        end
        #1;
        n_vec++;
        if (pix_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle_ready: got %b want 1", pix_ready); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (clear_done !== 1'b0 || ram_we !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL abort_no_done: %0d cycles with done/we high want 0", bad); end
        for (int i = 0; i <= 1000; i++) ref_img[i] = 1'b0;
        drops_model = 0;
    endtask

    task automatic test_read_mask();
        step();
        pix_valid = 1'b1; pix_x = 10'd0; pix_y = 10'd0; pix_data = 1'b1;
        step();
        pix_valid = 1'b0;
        n_vec++;
        if (ram_we !== 1'b1 || ram_write_address !== 19'd0 || ram_data_In !== 1'b1) begin
            n_err++; $display("FAIL mask_setup_write: we=%b addr=%0d dat=%b want 1/0/1", ram_we, ram_write_address, ram_data_In);
        end
        ref_img[0] = 1'b1;
        step();
        DrawX = 10'd700; DrawY = 10'd10;
        step();
        n_vec++;
        if (ram_read_address !== 19'd0) begin n_err++; $display("FAIL mask_raddr: got %0d want 0", ram_read_address); end
        DrawX = 10'd0; DrawY = 10'd0;
        step();
        n_vec++;
        if (pixel_on !== 1'b0) begin n_err++; $display("FAIL mask_blank: pixel_on=%b want 0", pixel_on); end
        step();
        n_vec++;
        if (pixel_on !== 1'b1) begin n_err++; $display("FAIL mask_word0: pixel_on=%b want 1", pixel_on); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pixel_corner();
        test_drop_single();
        test_back_to_back();
        test_read_stream();
        test_drop_saturate();
        test_clear();
        test_reset_mid_clear();
        test_read_mask();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
